// File: rtl/mcif_rsp_route5_pkg.sv
// Shared definitions for the mcif response router: client port count,
// arbiter id width, default tag depth and the router FSM encoding.
package mcif_rsp_route5_pkg;

    localparam int MCIF_ARB_PORT_NUM  = 5;
    localparam int MCIF_ARB_ID_W      = 3;
    localparam int MCIF_RSP_TAG_DEPTH = 8;

    typedef enum logic {
        MCIF_RSP_IDLE  = 1'b0,
        MCIF_RSP_BURST = 1'b1
    } rsp_state_e;

    // An id names a real client port only when it is below the port count.
    function automatic logic is_valid_id(input logic [MCIF_ARB_ID_W-1:0] id);
        return id < MCIF_ARB_ID_W'(MCIF_ARB_PORT_NUM);
    endfunction

endpackage

// File: rtl/mcif_tag_fifo.sv
// Outstanding-command tag FIFO: synchronous, power-of-two depth, head entry
// visible combinationally so the router can load it in the pop cycle.
module mcif_tag_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // The extra pointer bit separates "full" from "empty" when indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; a push while full is ignored here as well.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Storage write.
    // NOTE: the array has no reset; the pointers alone define which entries
    // are valid, so clearing the storage would add nothing.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/mcif_rsp_route5.sv
// Return-path router for the 5-way read arbiter. Records every issued
// {id, len} in a tag FIFO and steers in-order memory response beats to the
// owning client with zero latency. Beats for ids above 4 are discarded.
// Optional build macro MCIF_RSP_STALL_CNT_EN adds stall_cnt[15:0], a
// saturating count of BURST cycles where a beat is offered but not taken.
module mcif_rsp_route5
    import mcif_rsp_route5_pkg::*;
#(
    parameter int DW        = 64,
    parameter int LENW      = 4,
    parameter int TAG_DEPTH = MCIF_RSP_TAG_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_vld,
    input  logic [MCIF_ARB_ID_W-1:0]      cmd_id,
    input  logic [LENW-1:0]               cmd_len,
    output logic                          cmd_rdy,
    input  logic                          rsp_vld,
    input  logic [DW-1:0]                 rsp_data,
    output logic                          rsp_rdy,
    output logic [MCIF_ARB_PORT_NUM-1:0]  cli_rsp_vld,
    output logic [DW-1:0]                 cli_rsp_data,
    output logic                          cli_rsp_last,
    input  logic [MCIF_ARB_PORT_NUM-1:0]  cli_rsp_rdy,
    output logic                          err_bad_id,
    output logic                          err_orphan
`ifdef MCIF_RSP_STALL_CNT_EN
   ,output logic [15:0]                   stall_cnt
`endif
);

    localparam int TW = MCIF_ARB_ID_W + LENW;

    rsp_state_e               r_state;
    logic [MCIF_ARB_ID_W-1:0] r_cur_id;
    logic [LENW-1:0]          r_cur_len;
    logic [LENW-1:0]          r_beat_cnt;
    logic                     r_err_bad_id;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic [TW-1:0]            w_head;
    logic [MCIF_ARB_ID_W-1:0] w_head_id;
    logic [LENW-1:0]          w_head_len;
    logic                     w_burst;
    logic                     w_cur_good;
    logic                     w_last;
    logic                     w_hs;

    assign w_head_id  = w_head[TW-1:LENW];
    assign w_head_len = w_head[LENW-1:0];

    // cmd_rdy is only the registered full flag; a same-cycle pop never
    // bypasses it, so a command offered while full is simply dropped.
    assign cmd_rdy    = !w_full;
    assign w_push     = cmd_vld && !w_full;

    assign w_burst    = (r_state == MCIF_RSP_BURST);
    assign w_cur_good = is_valid_id(r_cur_id);
    assign w_last     = (r_beat_cnt == r_cur_len);
    assign w_hs       = rsp_vld && rsp_rdy;

    // Pop when idle with work queued, or on the final beat of a burst so the
    // next burst follows without a bubble.
    assign w_pop = !w_empty &&
                   ((r_state == MCIF_RSP_IDLE) || (w_burst && w_hs && w_last));

    mcif_tag_fifo #(
        .W     (TW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({cmd_id, cmd_len}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign cli_rsp_data = rsp_data;
    assign err_bad_id   = r_err_bad_id;

    // Zero-latency steering of the current beat to the owning client.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        rsp_rdy      = 1'b0;
        cli_rsp_vld  = '0;
        cli_rsp_last = 1'b0;
        err_orphan   = (r_state == MCIF_RSP_IDLE) && rsp_vld && w_empty;
        if (w_burst) begin
            if (w_cur_good) begin
                cli_rsp_last = w_last;
                for (int i = 0; i < MCIF_ARB_PORT_NUM; i++) begin
                    if (r_cur_id == MCIF_ARB_ID_W'(i)) begin
                        cli_rsp_vld[i] = rsp_vld;
                        rsp_rdy        = cli_rsp_rdy[i];
                    end
                end
            end else begin
                rsp_rdy = 1'b1;
            end
        end
    end

    // Burst tracking FSM: loads the FIFO head, counts beats, chains bursts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= MCIF_RSP_IDLE;
            r_cur_id     <= '0;
            r_cur_len    <= '0;
            r_beat_cnt   <= '0;
            r_err_bad_id <= 1'b0;
        end else begin
            if (w_pop && !is_valid_id(w_head_id)) r_err_bad_id <= 1'b1;
            case (r_state)
                MCIF_RSP_IDLE: begin
                    if (!w_empty) begin
                        r_cur_id   <= w_head_id;
                        r_cur_len  <= w_head_len;
                        r_beat_cnt <= '0;
                        r_state    <= MCIF_RSP_BURST;
                    end
                end
                MCIF_RSP_BURST: begin
                    if (w_hs) begin
                        if (!w_last) begin
                            r_beat_cnt <= r_beat_cnt + LENW'(1);
                        end else if (!w_empty) begin
                            r_cur_id   <= w_head_id;
                            r_cur_len  <= w_head_len;
                            r_beat_cnt <= '0;
                        end else begin
                            r_state <= MCIF_RSP_IDLE;
                        end
                    end
                end
                default: r_state <= MCIF_RSP_IDLE;
            endcase
        end
    end

`ifdef MCIF_RSP_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    assign stall_cnt = r_stall_cnt;

    // Saturating count of cycles where memory offers a beat the client stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_burst && rsp_vld && !rsp_rdy && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mcif_rsp_route5.sv
// Self-checking bench for mcif_rsp_route5. A queue of outstanding commands
// plus a beat index forms the reference: the head command tells which
// client owns the current beat and whether it is the last one.
`timescale 1ns/1ps
module tb_mcif_rsp_route5;

    localparam int DW    = 64;
    localparam int LENW  = 4;
    localparam int DEPTH = 8;
    localparam int NP    = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_vld = 1'b0;
    logic [2:0]      cmd_id = '0;
    logic [LENW-1:0] cmd_len = '0;
    logic            cmd_rdy;
    logic            rsp_vld = 1'b0;
    logic [DW-1:0]   rsp_data = '0;
    logic            rsp_rdy;
    logic [NP-1:0]   cli_rsp_vld;
    logic [DW-1:0]   cli_rsp_data;
    logic            cli_rsp_last;
    logic [NP-1:0]   cli_rsp_rdy = '0;
    logic            err_bad_id;
    logic            err_orphan;
`ifdef MCIF_RSP_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    mcif_rsp_route5 #(.DW(DW), .LENW(LENW), .TAG_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_vld      (cmd_vld),
        .cmd_id       (cmd_id),
        .cmd_len      (cmd_len),
        .cmd_rdy      (cmd_rdy),
        .rsp_vld      (rsp_vld),
        .rsp_data     (rsp_data),
        .rsp_rdy      (rsp_rdy),
        .cli_rsp_vld  (cli_rsp_vld),
        .cli_rsp_data (cli_rsp_data),
        .cli_rsp_last (cli_rsp_last),
        .cli_rsp_rdy  (cli_rsp_rdy),
        .err_bad_id   (err_bad_id),
        .err_orphan   (err_orphan)
`ifdef MCIF_RSP_STALL_CNT_EN
       ,.stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int len;
    } cmd_t;

    cmd_t cmd_q[$];
    int   beat_idx = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one command; the model keeps it only if the tag FIFO has room
    // (one outstanding command is held in the burst registers, not the FIFO).
    task automatic push_cmd(input int id, input int len);
        bit acc;
        acc = (cmd_q.size() == 0) || ((cmd_q.size() - 1) < DEPTH);
        cmd_vld = 1'b1;
        cmd_id  = 3'(id);
        cmd_len = LENW'(len);
        #4;
        check("cmd_rdy_on_push", {63'd0, cmd_rdy}, {63'd0, acc});
        step();
        cmd_vld = 1'b0;
        if (acc) cmd_q.push_back('{id, len});
    endtask

    // One response cycle with the inputs the caller set: compare routing with
    // the head command, then retire the beat in the model on a handshake.
    task automatic beat_cycle(input string tag);
        int            id;
        int            len;
        bit            good;
        logic [NP-1:0] ev;
        logic          er;
        #4;
        if (cmd_q.size() > 0) begin
            id   = cmd_q[0].id;
            len  = cmd_q[0].len;
            good = (id < NP);
            ev   = '0;
            er   = 1'b1;
            if (good) begin
                if (rsp_vld) ev[id] = 1'b1;
                er = cli_rsp_rdy[id];
            end
            check({tag, "_vld"}, 64'(cli_rsp_vld), 64'(ev));
            check({tag, "_rdy"}, {63'd0, rsp_rdy}, {63'd0, er});
            if (good) check({tag, "_last"}, {63'd0, cli_rsp_last}, {63'd0, (beat_idx == len)});
            if (rsp_vld) check({tag, "_data"}, cli_rsp_data, rsp_data);
            check({tag, "_orphan"}, {63'd0, err_orphan}, 64'd0);
            if (rsp_vld && er) begin
                if (beat_idx == len) begin
                    void'(cmd_q.pop_front());
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end
        end
        step();
    endtask

    // Random ready/valid traffic until the model has no commands left.
    task automatic drain(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (cmd_q.size() > 0 && cyc < budget) begin
            rsp_vld     = ($urandom_range(0, 3) != 0);
            rsp_data    = {$urandom, $urandom};
            cli_rsp_rdy = NP'($urandom | $urandom);
            beat_cycle(tag);
            cyc++;
        end
        rsp_vld = 1'b0;
        check({tag, "_left"}, 64'(cmd_q.size()), 64'd0);
    endtask

    task automatic idle_check(input string tag);
        cli_rsp_rdy = '1;
        #4;
        check({tag, "_idle_rdy"}, {63'd0, rsp_rdy}, 64'd0);
        check({tag, "_idle_vld"}, 64'(cli_rsp_vld), 64'd0);
        check({tag, "_idle_last"}, {63'd0, cli_rsp_last}, 64'd0);
        step();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nb;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_rdy", {63'd0, cmd_rdy}, 64'd1);
        check("rst_rsp_rdy", {63'd0, rsp_rdy}, 64'd0);
        check("rst_vld", 64'(cli_rsp_vld), 64'd0);
        check("rst_bad_id", {63'd0, err_bad_id}, 64'd0);
        rst = 1'b0;
        step();
        check("post_rst_cmd_rdy", {63'd0, cmd_rdy}, 64'd1);
        check("post_rst_orphan", {63'd0, err_orphan}, 64'd0);
`ifdef MCIF_RSP_STALL_CNT_EN
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

        // Single 4-beat burst to client 2.
        push_cmd(2, 3);
        step();
        cli_rsp_rdy = '1;
        for (int b = 0; b < 4; b++) begin
            rsp_vld  = 1'b1;
            rsp_data = {$urandom, $urandom};
            beat_cycle("t1");
        end
        rsp_vld = 1'b0;
        idle_check("t1");

        // Two bursts back-to-back: single beat to client 0, two beats to 4.
        push_cmd(0, 0);
        push_cmd(4, 1);
        cli_rsp_rdy = '1;
        for (int b = 0; b < 3; b++) begin
            rsp_vld  = 1'b1;
            rsp_data = {$urandom, $urandom};
            beat_cycle("t2");
        end
        rsp_vld = 1'b0;
        idle_check("t2");

        // Client 3 stalls for five cycles while a beat is held.
        push_cmd(3, 1);
        step();
        rsp_vld     = 1'b1;
        rsp_data    = 64'hDEAD_BEEF_0123_4567;
        cli_rsp_rdy = 5'b10111;
        for (int c = 0; c < 5; c++) beat_cycle("t3_stall");
`ifdef MCIF_RSP_STALL_CNT_EN
        check("t3_stall_cnt", 64'(stall_cnt), 64'd5);
`endif
        cli_rsp_rdy = '1;
        for (int b = 0; b < 2; b++) beat_cycle("t3_go");
        rsp_vld = 1'b0;
        idle_check("t3");

        // Fill the tag FIFO, offer one more, then free a slot.
        for (int k = 0; k < DEPTH + 2; k++) push_cmd($urandom_range(0, NP - 1), $urandom_range(0, 3));
        nb          = cmd_q[0].len + 1;
        rsp_vld     = 1'b1;
        cli_rsp_rdy = '1;
        cmd_vld     = 1'b1;
        cmd_id      = 3'd1;
        cmd_len     = '0;
        for (int b = 0; b < nb; b++) begin
            check("t4_full", {63'd0, cmd_rdy}, 64'd0);
            rsp_data = {$urandom, $urandom};
            beat_cycle("t4_head");
        end
        cmd_vld = 1'b0;
        rsp_vld = 1'b0;
        #4;
        check("t4_rdy_after_pop", {63'd0, cmd_rdy}, 64'd1);
        step();
        drain("t4_drain", 2000);
        idle_check("t4");

        // Bad id: both beats swallowed even with every client not ready.
        push_cmd(6, 1);
        step();
        cli_rsp_rdy = '0;
        for (int b = 0; b < 2; b++) begin
            rsp_vld  = 1'b1;
            rsp_data = {$urandom, $urandom};
            beat_cycle("t5");
        end
        rsp_vld = 1'b0;
        check("t5_bad_id", {63'd0, err_bad_id}, 64'd1);
        idle_check("t5");

        // Random rounds over all eight ids.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int k = 0; k < n; k++) push_cmd($urandom_range(0, 7), $urandom_range(0, 3));
            step();
            drain("rnd", 3000);
            idle_check("rnd");
        end
        check("bad_id_sticky", {63'd0, err_bad_id}, 64'd1);

        // Orphan beat while nothing is tracked.
        rsp_vld = 1'b1;
        #4;
        check("t6_orphan", {63'd0, err_orphan}, 64'd1);
        check("t6_orphan_rdy", {63'd0, rsp_rdy}, 64'd0);
        step();
        rsp_vld = 1'b0;
        #4;
        check("t6_orphan_end", {63'd0, err_orphan}, 64'd0);
        step();

        // Reset in the middle of a burst.
        push_cmd(1, 3);
        step();
        cli_rsp_rdy = '1;
        for (int b = 0; b < 2; b++) begin
            rsp_vld  = 1'b1;
            rsp_data = {$urandom, $urandom};
            beat_cycle("t6_pre");
        end
        rsp_vld = 1'b0;
        rst     = 1'b1;
        #1;
        check("t6_rst_rdy", {63'd0, rsp_rdy}, 64'd0);
        check("t6_rst_vld", 64'(cli_rsp_vld), 64'd0);
        check("t6_rst_bad_id", {63'd0, err_bad_id}, 64'd0);
        check("t6_rst_cmd_rdy", {63'd0, cmd_rdy}, 64'd1);
        cmd_q.delete();
        beat_idx = 0;
        step();
        rst = 1'b0;
        step();
        check("t6_post_cmd_rdy", {63'd0, cmd_rdy}, 64'd1);
        check("t6_post_rsp_rdy", {63'd0, rsp_rdy}, 64'd0);
        check("t6_post_last", {63'd0, cli_rsp_last}, 64'd0);
`ifdef MCIF_RSP_STALL_CNT_EN
        check("t6_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        push_cmd(2, 0);
        step();
        rsp_vld  = 1'b1;
        rsp_data = {$urandom, $urandom};
        beat_cycle("t6_after");
        rsp_vld = 1'b0;
        idle_check("t6_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
